smz_mem_responder: RTL and testbench
====================================

// Module: smz_mem_responder
// PURPOSE
//  Memory-side responder for the native valid/ready memory bus. Sits below the SMZ layer: it
//  receives mem_wdata (ciphertext when the address is inside the secure zone) and returns
//  mem_rdata, which the layer decrypts. Word-addressed on-chip RAM with programmable wait
//  states, byte strobes and out-of-range error flagging. Optional secure-zone zeroize engine.
// PARAMETERS
//  MEM_WORDS    1024   number of 32-bit words in the array
//  WAIT_STATES  1      extra cycles between acceptance and mem_ready (0..15)
//  ADDR_BASE    32'h0  byte address mapped to word 0
// PORTS
//  clk          in   1   single clock, rising edge
//  resetn       in   1   asynchronous, active-low reset
//  mem_valid    in   1   request valid; held until mem_ready
//  mem_addr     in   32  byte address; bits [1:0] ignored
//  mem_wdata    in   32  write data (already encrypted by SMZ layer)
//  mem_wstrb    in   4   byte write enables; 4'b0000 = read
//  mem_ready    out  1   one-cycle completion pulse
//  mem_rdata    out  32  read data, valid while mem_ready=1
//  mem_error    out  1   with mem_ready: address out of range
//  smz_base     in   32  secure zone base (byte address), used by zeroize
//  smz_size     in   32  secure zone size in bytes, used by zeroize
//  zeroize_req  in   1   one-cycle request to clear the secure zone
//  zeroize_busy out  1   zeroize in progress
//  zeroize_done out  1   one-cycle pulse when zeroize completes
// BEHAVIOUR
//  - Reset: state IDLE, mem_ready=0, mem_rdata=0, mem_error=0, zeroize_busy=0, zeroize_done=0,
//    wait counter=0, pending-zeroize flag=0. RAM contents are not reset.
//  - Reset mid-operation: in-flight access is abandoned. No partial write. Back to IDLE.
//  - FSM IDLE -> WAIT -> RESP -> IDLE, plus ZERO (feature only).
//  - IDLE: if mem_valid=1, latch addr, wdata, wstrb; word index idx=(mem_addr-ADDR_BASE)>>2
//    (32-bit modular subtraction); in_range = idx < MEM_WORDS.
//    Go to WAIT if WAIT_STATES>0, else RESP.
//  - WAIT: count WAIT_STATES cycles, then RESP.
//  - Latency: mem_ready is asserted WAIT_STATES+1 cycles after the accepting edge.
//  - RESP: mem_ready=1 for exactly one cycle, then IDLE. mem_ready is never high on two
//    consecutive cycles; next acceptance occurs no earlier than the cycle after RESP.
//  - Write (wstrb!=0, in_range): update only the bytes whose strobe bit is set, committed on
//    the RESP edge. mem_rdata=0.
//  - Read (wstrb=0, in_range): mem_rdata=RAM[idx], registered.
//  - Out of range: write dropped, mem_rdata=32'h0, mem_error=1 with mem_ready.
//  - mem_rdata and mem_error return to 0 the cycle after RESP.
//  - mem_valid dropping before mem_ready is a protocol violation: the latched access still
//    completes and its ready pulse is ignored by the master.
// CONFIGURATION
//  SMZ_ZEROIZE_EN defined:
//  - zeroize_req seen in IDLE: enter ZERO.
//  - zeroize_req seen in WAIT/RESP: set pending flag; enter ZERO right after RESP.
//  - ZERO: zeroize_busy=1. Write 32'h0 to one word per cycle, from
//    (smz_base-ADDR_BASE)>>2 through (smz_base+smz_size-1-ADDR_BASE)>>2, clipped to
//    [0,MEM_WORDS-1]. Partial end words are cleared whole.
//  - Bus requests are not accepted and get no mem_ready until the engine is back in IDLE.
//  - On completion: zeroize_done=1 for one cycle, busy=0, return to IDLE.
//  - smz_size=0 or zone fully outside the array: no writes; zeroize_done pulses the cycle
//    after the request is taken.
//  - zeroize_req while busy is ignored.
//  - smz_base/smz_size are sampled when ZERO is entered.
//  SMZ_ZEROIZE_EN undefined:
//  - zeroize_req ignored; zeroize_busy=0 and zeroize_done=0 permanently; no ZERO state.
// TESTING
//  1 WAIT_STATES=1: write 0xA5A5A5A5 @0x10 wstrb=F -> ready 2 cycles after accept;
//    read @0x10 -> rdata 0xA5A5A5A5, error=0.
//  2 Byte strobes: word=0x11223344, write 0xFFFFFFFF wstrb=4'b0101 -> read 0x11FF33FF.
//  3 Out of range: read @ADDR_BASE+4*MEM_WORDS -> ready, error=1, rdata=0;
//    write there leaves RAM unchanged.
//  4 WAIT_STATES=0, back-to-back valid: ready every other cycle, never two consecutive.
//  5 SMZ_ZEROIZE_EN, base=0x40, size=0x10: fill 0x00..0x7C nonzero, pulse req ->
//    busy 4 cycles, done pulse; words 0x40..0x4C read 0, neighbours 0x3C and 0x50 unchanged.
//  6 resetn low during WAIT of a write to 0x20 -> outputs 0, old word at 0x20 unchanged,
//    next read ready after WAIT_STATES+1.

Source files
------------

// File: rtl/smz_mem_responder.sv
// rtl/smz_mem_responder.sv - word-addressed RAM responder for the SMZ native memory bus
// Optional feature macro: SMZ_ZEROIZE_EN (secure-zone zeroize engine)
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   mem_valid, mem_addr, mem_wdata,  request; mem_wstrb == 0 means read,
//   mem_wstrb                        mem_addr[1:0] ignored
//   mem_ready, mem_rdata, mem_error  one-cycle response pulse with data / out-of-range flag
//   smz_base, smz_size               secure zone, sampled when a zeroize starts
//   zeroize_req, zeroize_busy,       zeroize request pulse, in-progress flag,
//   zeroize_done                     completion pulse
module smz_mem_responder #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ADDR_BASE   = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_error,
  input  logic [31:0] smz_base,
  input  logic [31:0] smz_size,
  input  logic        zeroize_req,
  output logic        zeroize_busy,
  output logic        zeroize_done
);

  localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] WORDS32   = 32'(MEM_WORDS);
  localparam logic [3:0]  WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

`ifdef SMZ_ZEROIZE_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_ZERO} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
`endif

  state_t state, state_next;

  logic [31:0]   ram [MEM_WORDS];
  logic [AW-1:0] idx_q;
  logic          in_range_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic [3:0]    wait_cnt;
  logic [31:0]   rdata_q;
  logic          error_q;

  logic [31:0]   req_idx;
  logic          req_in_range;
  logic          zero_go_idle;
  logic          zero_go_resp;
  logic          accept;
  logic          enter_resp;
  logic [AW-1:0] rd_idx;
  logic          rd_in_range;
  logic          rd_is_read;

  // Index of the live request; only meaningful on the accepting edge.
  assign req_idx      = (mem_addr - ADDR_BASE) >> 2;
  assign req_in_range = req_idx < WORDS32;

  // A zeroize request in IDLE wins over a simultaneous bus request.
  assign accept     = (state == S_IDLE) && mem_valid && !zero_go_idle;
  assign enter_resp = (accept && (WAIT_STATES == 0)) ||
                      ((state == S_WAIT) && (wait_cnt == WAIT_LAST));

  // With zero wait states the read happens on the accepting edge, so the
  // live request must be used instead of the latched one.
  assign rd_idx      = (state == S_IDLE) ? req_idx[AW-1:0] : idx_q;
  assign rd_in_range = (state == S_IDLE) ? req_in_range : in_range_q;
  assign rd_is_read  = (state == S_IDLE) ? (mem_wstrb == 4'b0) : (wstrb_q == 4'b0);

`ifdef SMZ_ZEROIZE_EN
  logic          pend_q;
  logic          done_q;
  logic [AW-1:0] zero_ptr;
  logic [AW-1:0] zero_last;
  logic [31:0]   zone_lo;
  logic [31:0]   zone_lo_w;
  logic [32:0]   zone_hi_byte;
  logic [32:0]   zone_hi_w;
  logic          zone_empty;
  logic [AW-1:0] zone_end;

  assign zone_lo      = smz_base - ADDR_BASE;
  assign zone_lo_w    = zone_lo >> 2;
  // One extra bit so a zone running past 4 GiB still clips to the last word.
  assign zone_hi_byte = {1'b0, zone_lo} + {1'b0, smz_size} - 33'd1;
  assign zone_hi_w    = zone_hi_byte >> 2;
  assign zone_empty   = (smz_size == 32'h0) || (zone_lo_w >= WORDS32);
  assign zone_end     = (zone_hi_w >= {1'b0, WORDS32}) ? AW'(MEM_WORDS - 1) : zone_hi_w[AW-1:0];

  assign zero_go_idle = (state == S_IDLE) && zeroize_req;
  assign zero_go_resp = (state == S_RESP) && (pend_q || zeroize_req);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
      zero_ptr  <= '0;
      zero_last <= '0;
    end else begin
      done_q <= 1'b0;
      pend_q <= (state == S_WAIT) ? (pend_q | zeroize_req) : 1'b0;
      if (zero_go_idle || zero_go_resp) begin
        if (zone_empty) begin
          done_q <= 1'b1;
        end else begin
          zero_ptr  <= zone_lo_w[AW-1:0];
          zero_last <= zone_end;
        end
      end else if (state == S_ZERO) begin
        zero_ptr <= zero_ptr + 1'b1;
        if (zero_ptr == zero_last) done_q <= 1'b1;
      end
    end
  end
`else
  logic unused_zero;
  assign unused_zero  = ^{zeroize_req, smz_base, smz_size};
  assign zero_go_idle = 1'b0;
  assign zero_go_resp = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) state_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
`ifdef SMZ_ZEROIZE_EN
        if (zero_go_idle && !zone_empty) state_next = S_ZERO;
`endif
      end
      S_WAIT: if (wait_cnt == WAIT_LAST) state_next = S_RESP;
      S_RESP: begin
        state_next = S_IDLE;
`ifdef SMZ_ZEROIZE_EN
        if (zero_go_resp && !zone_empty) state_next = S_ZERO;
`endif
      end
`ifdef SMZ_ZEROIZE_EN
      S_ZERO: if (zero_ptr == zero_last) state_next = S_IDLE;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    mem_ready    = (state == S_RESP);
    mem_rdata    = rdata_q;
    mem_error    = error_q;
    zeroize_busy = 1'b0;
    zeroize_done = 1'b0;
`ifdef SMZ_ZEROIZE_EN
    zeroize_busy = (state == S_ZERO);
    zeroize_done = done_q;
`endif
  end

  // Request latch, wait counter and response data
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx_q      <= '0;
      in_range_q <= 1'b0;
      wdata_q    <= 32'h0;
      wstrb_q    <= 4'h0;
      wait_cnt   <= 4'h0;
      rdata_q    <= 32'h0;
      error_q    <= 1'b0;
    end else begin
      if (accept) begin
        idx_q      <= req_idx[AW-1:0];
        in_range_q <= req_in_range;
        wdata_q    <= mem_wdata;
        wstrb_q    <= mem_wstrb;
      end
      wait_cnt <= (state == S_WAIT) ? wait_cnt + 4'd1 : 4'd0;
      if (enter_resp) begin
        rdata_q <= (rd_is_read && rd_in_range) ? ram[rd_idx] : 32'h0;
        error_q <= !rd_in_range;
      end else if (state == S_RESP) begin
        rdata_q <= 32'h0;
        error_q <= 1'b0;
      end
    end
  end

  // RAM: writes land on the RESP edge only, so a reset during WAIT drops them.
  always_ff @(posedge clk) begin
    if ((state == S_RESP) && in_range_q) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) ram[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
`ifdef SMZ_ZEROIZE_EN
    if (state == S_ZERO) ram[zero_ptr] <= 32'h0;
`endif
  end

endmodule

// File: tb/tb_smz_mem_responder.sv
// tb/tb_smz_mem_responder.sv - self-checking bench for smz_mem_responder
module tb_smz_mem_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  wstrb [3];
  logic        ready [3];
  logic [31:0] rdata [3];
  logic        error [3];
  logic [31:0] zbase [3];
  logic [31:0] zsize [3];
  logic        zreq  [3];
  logic        zbusy [3];
  logic        zdone [3];

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] model [3][64];

  always #5 clk = ~clk;

  // Three configurations: WS=1 base 0, WS=0 base 0x1000, WS=3 base 0.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    smz_mem_responder #(
      .MEM_WORDS  (g == 0 ? 64 : (g == 1 ? 32 : 16)),
      .WAIT_STATES(g == 0 ? 1 : (g == 1 ? 0 : 3)),
      .ADDR_BASE  (g == 1 ? 32'h1000 : 32'h0)
    ) u_dut (
      .clk         (clk),
      .resetn      (resetn),
      .mem_valid   (valid[g]),
      .mem_addr    (addr[g]),
      .mem_wdata   (wdata[g]),
      .mem_wstrb   (wstrb[g]),
      .mem_ready   (ready[g]),
      .mem_rdata   (rdata[g]),
      .mem_error   (error[g]),
      .smz_base    (zbase[g]),
      .smz_size    (zsize[g]),
      .zeroize_req (zreq[g]),
      .zeroize_busy(zbusy[g]),
      .zeroize_done(zdone[g])
    );
  end

  function automatic int mw(input int d);
    return (d == 0) ? 64 : ((d == 1) ? 32 : 16);
  endfunction
  function automatic int ws(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction
  function automatic logic [31:0] base(input int d);
    return (d == 1) ? 32'h1000 : 32'h0;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, got, exp);
    end
  endtask

  // Reference: byte-mask merge on a word array, error for anything past the array.
  task automatic predict(input int d, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] st, output logic [31:0] exp_rd, output logic exp_er);
    logic [31:0] off;
    logic [31:0] mask;
    off = a - base(d);
    exp_rd = 32'h0;
    exp_er = 1'b0;
    if (off / 4 >= 32'(mw(d))) begin
      exp_er = 1'b1;
    end else if (st == 4'b0) begin
      exp_rd = model[d][off / 4];
    end else begin
      mask = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
      model[d][off / 4] = (model[d][off / 4] & ~mask) | (wd & mask);
    end
  endtask

  task automatic access(input int d, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, output logic [31:0] rd, output logic er,
                        output int lat);
    valid[d] = 1'b1;
    addr[d]  = a;
    wdata[d] = wd;
    wstrb[d] = st;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!ready[d] && lat < 40);
    rd = rdata[d];
    er = error[d];
    valid[d] = 1'b0;
    wstrb[d] = 4'h0;
    @(negedge clk);
    check("after_resp_clear", {ready[d], error[d], rdata[d]}, 64'h0);
  endtask

  task automatic txn(input int d, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] st, input string tag);
    logic [31:0] exp_rd, rd;
    logic        exp_er, er;
    int          lat;
    predict(d, a, wd, st, exp_rd, exp_er);
    access(d, a, wd, st, rd, er, lat);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_error"}, er, exp_er);
    check({tag, "_latency"}, lat, ws(d) + 1);
  endtask

  typedef struct {
    int          d;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  vec_t vecs [17];

  initial begin
    #900000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, dummy_rd;
    logic        er, dummy_er;
    int          lat;

    vecs[0]  = '{0, 32'h10,   32'hA5A5A5A5, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{0, 32'h10,   32'h0,        4'h0, 32'hA5A5A5A5, 1'b0};
    vecs[2]  = '{0, 32'h14,   32'h11223344, 4'hF, 32'h0,        1'b0};
    vecs[3]  = '{0, 32'h14,   32'hFFFFFFFF, 4'h5, 32'h0,        1'b0};
    vecs[4]  = '{0, 32'h14,   32'h0,        4'h0, 32'h11FF33FF, 1'b0};
    vecs[5]  = '{0, 32'h0,    32'h01020304, 4'hF, 32'h0,        1'b0};
    vecs[6]  = '{0, 32'h100,  32'h0,        4'h0, 32'h0,        1'b1};
    vecs[7]  = '{0, 32'h100,  32'hDEADBEEF, 4'hF, 32'h0,        1'b1};
    vecs[8]  = '{0, 32'h0,    32'h0,        4'h0, 32'h01020304, 1'b0};
    vecs[9]  = '{1, 32'h1004, 32'hCAFEBABE, 4'hF, 32'h0,        1'b0};
    vecs[10] = '{1, 32'h1004, 32'h0,        4'h0, 32'hCAFEBABE, 1'b0};
    vecs[11] = '{1, 32'h1080, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[12] = '{1, 32'h0FFC, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[13] = '{1, 32'h1000, 32'h0,        4'hF, 32'h0,        1'b0};
    vecs[14] = '{1, 32'h1003, 32'h12345678, 4'h8, 32'h0,        1'b0};
    vecs[15] = '{1, 32'h1001, 32'h0,        4'h0, 32'h12000000, 1'b0};
    vecs[16] = '{2, 32'h40,   32'h0,        4'h0, 32'h0,        1'b1};

    for (int d = 0; d < 3; d++) begin
      valid[d] = 1'b0; addr[d] = 32'h0; wdata[d] = 32'h0; wstrb[d] = 4'h0;
      zbase[d] = 32'h0; zsize[d] = 32'h0; zreq[d] = 1'b0;
    end
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("reset_outputs", {ready[d], error[d], zbusy[d], zdone[d], rdata[d]}, 64'h0);
    end
    resetn = 1'b1;
    @(negedge clk);

    // Prefill every word with a nonzero value so the model covers the whole array.
    for (int d = 0; d < 3; d++) begin
      for (int w = 0; w < mw(d); w++) begin
        txn(d, base(d) + 32'(4 * w), $urandom | 32'h1, 4'hF, "prefill");
      end
    end

    // Directed table
    for (int i = 0; i < 17; i++) begin
      predict(vecs[i].d, vecs[i].a, vecs[i].wd, vecs[i].st, dummy_rd, dummy_er);
      access(vecs[i].d, vecs[i].a, vecs[i].wd, vecs[i].st, rd, er, lat);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_error", i), er, vecs[i].exp_er);
      check($sformatf("vec%0d_latency", i), lat, ws(vecs[i].d) + 1);
    end

    // Back-to-back reads with zero wait states: ready every other cycle.
    predict(1, 32'h1004, 32'h0, 4'h0, rd, er);
    valid[1] = 1'b1; addr[1] = 32'h1004; wstrb[1] = 4'h0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("b2b_ready_%0d", i), ready[1], (i % 2) == 0);
      if (ready[1]) check("b2b_rdata", rdata[1], rd);
    end
    valid[1] = 1'b0;
    @(negedge clk);
    check("b2b_idle", ready[1], 1'b0);

    // Reset in the middle of a write's wait period: the write must not land.
    valid[2] = 1'b1; addr[2] = 32'h20; wdata[2] = 32'h5A5A5A5A; wstrb[2] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    valid[2] = 1'b0; wstrb[2] = 4'h0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check("midreset_outputs", {ready[d], error[d], rdata[d]}, 64'h0);
    end
    @(posedge clk);
    @(negedge clk);
    check("midreset_held", {ready[2], error[2], rdata[2]}, 64'h0);
    resetn = 1'b1;
    @(negedge clk);
    txn(2, 32'h20, 32'h0, 4'h0, "midreset_read");

`ifdef SMZ_ZEROIZE_EN
    begin
      int nbusy, donecyc;
      zbase[0] = 32'h40; zsize[0] = 32'h10; zreq[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      zreq[0] = 1'b0;
      nbusy = 0; donecyc = -1;
      for (int k = 0; k < 20; k++) begin
        if (zbusy[0]) nbusy++;
        if (zdone[0] && donecyc < 0) donecyc = k;
        @(negedge clk);
      end
      check("zero_busy_cycles", nbusy, 4);
      check("zero_done_cycle", donecyc, 4);
      for (int w = 16; w < 20; w++) model[0][w] = 32'h0;
      for (int w = 15; w < 21; w++) txn(0, 32'(4 * w), 32'h0, 4'h0, "zero_read");
      zsize[0] = 32'h0; zreq[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      zreq[0] = 1'b0;
      check("zero_empty", {zdone[0], zbusy[0]}, 2'b10);
      @(negedge clk);
      check("zero_empty_after", {zdone[0], zbusy[0]}, 2'b00);
    end
`else
    for (int d = 0; d < 3; d++) begin
      zbase[d] = base(d); zsize[d] = 32'h40; zreq[d] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) zreq[d] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int d = 0; d < 3; d++) check("zero_disabled", {zbusy[d], zdone[d]}, 2'b00);
      @(negedge clk);
    end
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 360; i++) begin
      int          d;
      logic [31:0] a;
      logic [3:0]  st;
      d  = i % 3;
      a  = ($urandom_range(0, 9) == 0) ? $urandom
                                       : base(d) + 32'($urandom_range(0, 4 * mw(d) + 15));
      st = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      txn(d, a, $urandom, st, "random");
    end

    // Final sweep: every word must match the model.
    for (int d = 0; d < 3; d++) begin
      for (int w = 0; w < mw(d); w++) begin
        txn(d, base(d) + 32'(4 * w), 32'h0, 4'h0, "sweep");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
